// File: rtl/fault_capture_regs_4mb.sv
// N-channel fault capture bank: synchroniser, debounce, live/sticky status, masked interrupt.
// Optional event counter at BASE+4 is built only when FLT_EVT_CNT_EN is defined.

module fault_capture_regs_4mb_ch #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flt_i,
  input  logic [DEB_W-1:0] thr_i,
  output logic             live_o,
  output logic             rise_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DEB_W-1:0]       cnt_q, cnt_d;
  logic                   live_q, live_d, sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // >= rather than == so a counter stranded above a lowered threshold still resolves
  always_comb begin
    live_d = live_q;
    cnt_d  = '0;
    if (sync_s != live_q) begin
      if (cnt_q >= thr_i) live_d = sync_s;
      else                cnt_d  = cnt_q + DEB_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      live_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], flt_i};
      cnt_q  <= cnt_d;
      live_q <= live_d;
    end
  end

  assign live_o = live_q;
  assign rise_o = live_d & ~live_q;
endmodule

module fault_capture_regs_4mb #(
  parameter int unsigned N_CH        = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_W       = 8,
  parameter int unsigned DEB_RST     = 10,
  parameter logic [31:0] MASK_RST    = 32'h0,
  parameter logic [15:0] ADDR_BASE   = 16'h0040
) (
  input  logic            clk_100m,
  input  logic            rst_n_syn,
  input  logic [N_CH-1:0] flt_in,
  input  logic [31:0]     data_mosi,
  input  logic            data_mosi_rdy,
  input  logic [15:0]     addr,
  output logic [31:0]     live_reg,
  output logic [31:0]     sticky_reg,
  output logic [31:0]     mask_reg,
  output logic [31:0]     deb_thr_reg,
  output logic [31:0]     evt_cnt_reg,
  output logic            flt_irq
);
  logic [N_CH-1:0]  live, rise;
  logic [N_CH-1:0]  sticky_q, sticky_d, mask_q, mask_d;
  logic [DEB_W-1:0] thr_q, thr_d;
  logic             irq_q;
  logic             wr_sticky, wr_mask, wr_thr;
  logic             unused_bits;

  assign unused_bits = ^data_mosi;

  assign wr_sticky = data_mosi_rdy && (addr == ADDR_BASE + 16'd1);
  assign wr_mask   = data_mosi_rdy && (addr == ADDR_BASE + 16'd2);
  assign wr_thr    = data_mosi_rdy && (addr == ADDR_BASE + 16'd3);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    fault_capture_regs_4mb_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_W       (DEB_W)
    ) u_ch (
      .clk_i   (clk_100m),
      .rst_n_i (rst_n_syn),
      .flt_i   (flt_in[i]),
      .thr_i   (thr_q),
      .live_o  (live[i]),
      .rise_o  (rise[i])
    );
  end

  // set after clear: a rise coinciding with a W1C must not be lost
  always_comb begin
    sticky_d = sticky_q;
    if (wr_sticky) sticky_d = sticky_q & ~data_mosi[N_CH-1:0];
    sticky_d = sticky_d | rise;
    mask_d   = wr_mask ? data_mosi[N_CH-1:0] : mask_q;
    thr_d    = wr_thr  ? data_mosi[DEB_W-1:0] : thr_q;
  end

  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) begin
      sticky_q <= '0;
      mask_q   <= MASK_RST[N_CH-1:0];
      thr_q    <= DEB_W'(DEB_RST);
      irq_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      mask_q   <= mask_d;
      thr_q    <= thr_d;
      irq_q    <= |(sticky_q & mask_q);
    end
  end

`ifdef FLT_EVT_CNT_EN
  logic [15:0] evt_q, evt_d;
  logic        evt_hit, wr_evt;

  assign wr_evt  = data_mosi_rdy && (addr == ADDR_BASE + 16'd4);
  assign evt_hit = |(rise & mask_q);

  always_comb begin
    evt_d = evt_q;
    if (wr_evt)                          evt_d = {15'd0, evt_hit};
    else if (evt_hit && evt_q != 16'hFFFF) evt_d = evt_q + 16'd1;
  end

  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) evt_q <= '0;
    else            evt_q <= evt_d;
  end

  assign evt_cnt_reg = {16'h0, evt_q};
`else
  assign evt_cnt_reg = 32'h0;
`endif

  always_comb begin
    live_reg                = '0;
    sticky_reg              = '0;
    mask_reg                = '0;
    deb_thr_reg             = '0;
    live_reg[N_CH-1:0]      = live;
    sticky_reg[N_CH-1:0]    = sticky_q;
    mask_reg[N_CH-1:0]      = mask_q;
    deb_thr_reg[DEB_W-1:0]  = thr_q;
  end

  assign flt_irq = irq_q;
endmodule
